// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: EX-stage ALU with integrated ALU-control decode.
//
// Decodes ALUOp/Funct/Opcode using standard MIPS encodings, executes the
// operation on WIDTH-bit operands and returns a registered result through a
// valid/ready handshake on both sides.
//   R-type funct : SLL 00 SRL 02 JR 08 MUL 18 ADD 20 SUB 22 AND 24 OR 25
//                  XOR 26 NOR 27 SLT 2A
//   I-type opcode: REGIMM 01 (Rt 0 = BLTZ, Rt 1 = BGEZ) BEQ 04 BNE 05 BLEZ 06
//                  BGTZ 07 ADDI 08 SLTI 0A ANDI 0C ORI 0D XORI 0E LB 20 LH 21
//                  LW 23 SB 28 SH 29 SW 2B
//   Jump opcode  : J 02 JAL 03
// MUL uses a one-bit-per-cycle shift-add multiplier when MUL_ITERATIVE=1.
//
// Ports:
//   Clk, Rst (async active-low)         clock / reset
//   In_Valid, In_Ready                  input handshake
//   ALUOp, Funct, Opcode, Rt            decode fields
//   A, B, Shamt                         operands
//   Out_Valid, Out_Ready                output handshake
//   Result, Zero, BranchTaken, Illegal  registered result and flags
//   Busy                                iterative multiply in progress
module alu_ctrl_exec #(
  parameter int WIDTH         = 32,
  parameter int MUL_ITERATIVE = 1,
  parameter int SHW           = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [5:0]       Opcode,
  input  logic [4:0]       Rt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             BranchTaken,
  output logic             Illegal,
  output logic             Busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               taken_q, taken_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]   dec_result_s;
  logic               dec_taken_s;
  logic               dec_illegal_s;
  logic               dec_mul_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   mul_fast_s;
  logic               a_neg_s;
  logic               a_zero_s;
  logic               accept_s;

  assign diff_s     = A - B;
  assign mul_fast_s = A * B;
  assign a_neg_s    = A[WIDTH-1];
  assign a_zero_s   = (A == '0);

  // Holding a result that nobody consumes, or any multiply in flight, stalls upstream.
  assign In_Ready = Rst && (state_q == S_IDLE) && (!out_valid_q || Out_Ready);
  assign accept_s = In_Valid && In_Ready;

  // Operation decode and single-cycle datapath.
  always_comb begin
    dec_result_s  = '0;
    dec_taken_s   = 1'b0;
    dec_illegal_s = 1'b0;
    dec_mul_s     = 1'b0;
    case (ALUOp)
      2'b00: begin
        case (Funct)
          6'h20:   dec_result_s = A + B;
          6'h22:   dec_result_s = A - B;
          6'h24:   dec_result_s = A & B;
          6'h25:   dec_result_s = A | B;
          6'h26:   dec_result_s = A ^ B;
          6'h27:   dec_result_s = ~(A | B);
          6'h00:   dec_result_s = B << Shamt;
          6'h02:   dec_result_s = B >> Shamt;
          6'h2A:   dec_result_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
          6'h18: begin
            dec_mul_s    = 1'b1;
            dec_result_s = (MUL_ITERATIVE != 0) ? '0 : mul_fast_s;
          end
          6'h08: begin
            dec_result_s = A;
            dec_taken_s  = 1'b1;
          end
          default: dec_illegal_s = 1'b1;
        endcase
      end
      2'b01: begin
        case (Opcode)
          6'h08, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: dec_result_s = A + B;
          6'h0C:   dec_result_s = A & B;
          6'h0D:   dec_result_s = A | B;
          6'h0E:   dec_result_s = A ^ B;
          6'h0A:   dec_result_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
          6'h04: begin
            dec_result_s = diff_s;
            dec_taken_s  = (A == B);
          end
          6'h05: begin
            dec_result_s = diff_s;
            dec_taken_s  = (A != B);
          end
          6'h06: begin
            dec_result_s = diff_s;
            dec_taken_s  = a_neg_s || a_zero_s;
          end
          6'h07: begin
            dec_result_s = diff_s;
            dec_taken_s  = !a_neg_s && !a_zero_s;
          end
          6'h01: begin
            // REGIMM: Rt picks the comparison; other Rt values are not recognised.
            if (Rt == 5'd0) begin
              dec_result_s = diff_s;
              dec_taken_s  = a_neg_s;
            end else if (Rt == 5'd1) begin
              dec_result_s = diff_s;
              dec_taken_s  = !a_neg_s;
            end else begin
              dec_illegal_s = 1'b1;
            end
          end
          default: dec_illegal_s = 1'b1;
        endcase
      end
      2'b10: begin
        case (Opcode)
          6'h02:   dec_taken_s = 1'b1;
          6'h03: begin
            dec_result_s = B;
            dec_taken_s  = 1'b1;
          end
          default: dec_illegal_s = 1'b1;
        endcase
      end
      default: dec_illegal_s = 1'b1;
    endcase
  end

  // Control FSM, handshake bookkeeping and shift-add multiplier step.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !Out_Ready;
    result_d    = result_q;
    zero_d      = zero_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    busy_d      = busy_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (dec_mul_s && (MUL_ITERATIVE != 0)) begin
            state_d  = S_MUL;
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            result_d    = dec_result_s;
            zero_d      = (dec_result_s == '0);
            taken_d     = dec_taken_s;
            illegal_d   = dec_illegal_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // WIDTH is a power of two, so the all-ones count marks the last bit.
        if (cnt_q == {SHW{1'b1}}) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        // Any earlier result was consumed when the multiply was accepted.
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        result_d    = acc_q;
        zero_d      = (acc_q == '0);
        taken_d     = 1'b0;
        illegal_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign Out_Valid   = out_valid_q;
  assign Result      = result_q;
  assign Zero        = zero_q;
  assign BranchTaken = taken_q;
  assign Illegal     = illegal_q;
  assign Busy        = busy_q;

endmodule
